// File: rtl/mem_line_bridge_pkg.sv
// Shared types and constants for the cache-line to RAM-word bridge.
package mem_line_bridge_pkg;

    localparam int ADDR_W        = 32;
    localparam int WORD_W        = 32;
    localparam int LINE_W        = 128;
    localparam int BEATS         = LINE_W / WORD_W;
    localparam int LINE_OFFSET_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic              rw;     // 1 = write-back, 0 = line fill
        logic              valid;
    } mem_req_type;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic              ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/mem_line_buf.sv
// 4x32 line register: whole-line load, single-slot write, slot read mux, clear.
module mem_line_buf
    import mem_line_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              we,
    input  logic [1:0]        wslot,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        rslot,
    output logic [WORD_W-1:0] rdata,
    output logic [LINE_W-1:0] line
);

    logic [WORD_W-1:0] slots [BEATS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < BEATS; k++) slots[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < BEATS; k++) slots[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < BEATS; k++) slots[k] <= load_line[k*WORD_W +: WORD_W];
        end else if (we) begin
            slots[wslot] <= wdata;
        end
    end

    always_comb begin
        line = '0;
        for (int k = 0; k < BEATS; k++) line[k*WORD_W +: WORD_W] = slots[k];
    end

    assign rdata = slots[rslot];

endmodule

// File: rtl/mem_line_bridge.sv
// Splits cache line requests into four ack-handshaked RAM word beats.
// Optional MEM_BRIDGE_CWF_EN: read beats start at the requested word and wrap.
// Handshake: ram_en holds with a stable address/data until ram_ack; a beat
// completes on the edge where both are high. mem_req.valid is a one-cycle strobe
// sampled only in IDLE and RESP; mem_data.ready is a one-cycle done pulse.
module mem_line_bridge
    import mem_line_bridge_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  mem_req_type         mem_req,
    output mem_data_type        mem_data,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-3:0]   ram_addr,
    output logic [WORD_W-1:0]   ram_wdata,
    input  logic [WORD_W-1:0]   ram_rdata,
    input  logic                ram_ack,
    output logic                busy,
    output bridge_state_t       dbg_state
);

    bridge_state_t state;
    logic [ADDR_W-LINE_OFFSET_W-1:0] line_addr;
    logic                rw_q;
    logic [1:0]          beat;
    logic [1:0]          cnt;
    logic                ready_q;
    logic [LINE_W-1:0]   resp_data;
    logic [1:0]          start_beat;
    logic                accept;
    logic                beat_done;
    logic [WORD_W-1:0]   buf_rdata;
    logic [LINE_W-1:0]   buf_line;
    logic [LINE_W-1:0]   merged_line;

    assign accept    = (state == ST_IDLE || state == ST_RESP) && mem_req.valid;
    assign beat_done = (state == ST_XFER) && ram_ack;

`ifdef MEM_BRIDGE_CWF_EN
    assign start_beat = mem_req.rw ? 2'd0 : mem_req.addr[3:2];
`else
    assign start_beat = 2'd0;
`endif

    mem_line_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept && !mem_req.rw),
        .load      (accept && mem_req.rw),
        .load_line (mem_req.data),
        .we        (beat_done && !rw_q),
        .wslot     (beat),
        .wdata     (ram_rdata),
        .rslot     (beat + 2'd1),
        .rdata     (buf_rdata),
        .line      (buf_line)
    );

    // The final read word lands in the buffer on the same edge, so merge it here.
    always_comb begin
        merged_line = buf_line;
        merged_line[beat*WORD_W +: WORD_W] = ram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            line_addr <= '0;
            rw_q      <= 1'b0;
            beat      <= '0;
            cnt       <= '0;
            ready_q   <= 1'b0;
            resp_data <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RESP: begin
                    ready_q <= 1'b0;
                    if (accept) begin
                        line_addr <= mem_req.addr[ADDR_W-1:LINE_OFFSET_W];
                        rw_q      <= mem_req.rw;
                        beat      <= start_beat;
                        cnt       <= '0;
                        ram_en    <= 1'b1;
                        ram_we    <= mem_req.rw;
                        ram_addr  <= {mem_req.addr[ADDR_W-1:LINE_OFFSET_W], start_beat};
                        ram_wdata <= mem_req.data[start_beat*WORD_W +: WORD_W];
                        state     <= ST_XFER;
                    end else begin
                        state     <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (ram_ack) begin
                        if (cnt == 2'd3) begin
                            ram_en  <= 1'b0;
                            ram_we  <= 1'b0;
                            ready_q <= 1'b1;
                            if (!rw_q) resp_data <= merged_line;
                            state   <= ST_RESP;
                        end else begin
                            beat      <= beat + 2'd1;
                            cnt       <= cnt + 2'd1;
                            ram_addr  <= {line_addr, beat + 2'd1};
                            ram_wdata <= buf_rdata;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_data.data  = resp_data;
    assign mem_data.ready = ready_q;
    assign busy           = (state != ST_IDLE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_mem_line_bridge.sv
// Directed bench for mem_line_bridge with a word = address RAM responder.
module tb_mem_line_bridge;
    import mem_line_bridge_pkg::*;

    logic          clk;
    logic          rst;
    mem_req_type   mem_req;
    mem_data_type  mem_data;
    logic          ram_en;
    logic          ram_we;
    logic [29:0]   ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          ram_ack;
    logic          busy;
    bridge_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;

    logic [29:0] b_addr;
    logic        b_we;
    logic [31:0] b_wdata;
    int          b_wait;
    logic [127:0] exp_line;
    logic [127:0] wr_line;
    logic [29:0]  exp_addr_q[$];
    logic [31:0]  exp_wdata_q[$];
    int           rc0;

    mem_line_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_data  (mem_data),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mem_data.ready) ready_cnt++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive a one-cycle request strobe at a negedge.
    task automatic send_req(input logic [31:0] addr, input logic rw, input logic [127:0] data);
        mem_req.addr  = addr;
        mem_req.rw    = rw;
        mem_req.data  = data;
        mem_req.valid = 1'b1;
        @(negedge clk);
        mem_req.valid = 1'b0;
    endtask

    // Serve one RAM beat: wait for ram_en, hold ack off for 'delay' cycles, then ack.
    task automatic do_beat(input int delay, output logic [29:0] a, output logic we,
                           output logic [31:0] wd, output int waited);
        waited = 0;
        while (!ram_en && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("beat_wait", {127'd0, ram_en}, 128'd1);
        a  = ram_addr;
        we = ram_we;
        wd = ram_wdata;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("hold_en", {127'd0, ram_en}, 128'd1);
            check("hold_addr", {98'd0, ram_addr}, {98'd0, a});
        end
        ram_ack   = 1'b1;
        ram_rdata = {2'b00, ram_addr};
        @(negedge clk);
        ram_ack   = 1'b0;
    endtask

    // Serve 4 beats and check them against the expected queues.
    task automatic run_line(input int delay, input logic exp_we);
        for (int k = 0; k < 4; k++) begin
            do_beat(delay, b_addr, b_we, b_wdata, b_wait);
            check("beat_gap", b_wait, (k == 0) ? 0 : 0);
            check("beat_addr", {98'd0, b_addr}, {98'd0, exp_addr_q.pop_front()});
            check("beat_we", {127'd0, b_we}, {127'd0, exp_we});
            if (exp_we) check("beat_wdata", {96'd0, b_wdata}, {96'd0, exp_wdata_q.pop_front()});
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_req = '0;
        ram_rdata = '0;
        ram_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_en", {127'd0, ram_en}, 128'd0);
        check("rst_ready", {127'd0, mem_data.ready}, 128'd0);
        check("rst_data", mem_data.data, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_addr", {98'd0, ram_addr}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read line 0x1230: beats 0x48C..0x48F, ready 4 edges after acceptance.
        exp_addr_q = '{30'h48C, 30'h48D, 30'h48E, 30'h48F};
        rc0 = ready_cnt;
        send_req(32'h0000_1230, 1'b0, '0);
        check("rd_first_en", {127'd0, ram_en}, 128'd1);
        run_line(0, 1'b0);
        check("rd_ready", {127'd0, mem_data.ready}, 128'd1);
        exp_line = {32'h48F, 32'h48E, 32'h48D, 32'h48C};
        check("rd_data", mem_data.data, exp_line);
        @(negedge clk);
        check("rd_ready_low", {127'd0, mem_data.ready}, 128'd0);
        check("rd_ready_cnt", ready_cnt - rc0, 128'd1);
        check("rd_idle", {127'd0, busy}, 128'd0);

        // Write to 0x40 with 2-cycle ack delay; data must not change mem_data.data.
        wr_line = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        exp_addr_q  = '{30'h10, 30'h11, 30'h12, 30'h13};
        exp_wdata_q = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
        rc0 = ready_cnt;
        send_req(32'h0000_0040, 1'b1, wr_line);
        run_line(2, 1'b1);
        check("wr_ready", {127'd0, mem_data.ready}, 128'd1);
        check("wr_data_kept", mem_data.data, exp_line);
        @(negedge clk);
        check("wr_ready_cnt", ready_cnt - rc0, 128'd1);

        // Write-back then allocate in the ready cycle.
        exp_addr_q  = '{30'h20, 30'h21, 30'h22, 30'h23};
        exp_wdata_q = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
        rc0 = ready_cnt;
        send_req(32'h0000_0080, 1'b1, {32'h4444_0000, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000});
        run_line(0, 1'b1);
        check("wb_ready", {127'd0, mem_data.ready}, 128'd1);
        send_req(32'h0000_0100, 1'b0, '0);
        check("alloc_en", {127'd0, ram_en}, 128'd1);
        check("alloc_addr", {98'd0, ram_addr}, 128'h40);
        exp_addr_q = '{30'h40, 30'h41, 30'h42, 30'h43};
        run_line(0, 1'b0);
        check("alloc_data", mem_data.data, {32'h43, 32'h42, 32'h41, 32'h40});
        @(negedge clk);
        check("alloc_ready_cnt", ready_cnt - rc0, 128'd2);

        // Reset after beat 1 of a read.
        rc0 = ready_cnt;
        send_req(32'h0000_0200, 1'b0, '0);
        do_beat(0, b_addr, b_we, b_wdata, b_wait);
        do_beat(0, b_addr, b_we, b_wdata, b_wait);
        rst = 1'b1;
        #1;
        check("mid_rst_en", {127'd0, ram_en}, 128'd0);
        check("mid_rst_ready", {127'd0, mem_data.ready}, 128'd0);
        check("mid_rst_busy", {127'd0, busy}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        @(negedge clk);
        check("late_ack_busy", {127'd0, busy}, 128'd0);
        check("late_ack_en", {127'd0, ram_en}, 128'd0);
        check("late_ack_ready", ready_cnt - rc0, 128'd0);
        exp_addr_q = '{30'hC0, 30'hC1, 30'hC2, 30'hC3};
        send_req(32'h0000_0300, 1'b0, '0);
        run_line(0, 1'b0);
        check("post_rst_data", mem_data.data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        @(negedge clk);

        // Critical-word-first order (plain order when the feature is off).
`ifdef MEM_BRIDGE_CWF_EN
        exp_addr_q = '{30'h0E, 30'h0F, 30'h0C, 30'h0D};
`else
        exp_addr_q = '{30'h0C, 30'h0D, 30'h0E, 30'h0F};
`endif
        send_req(32'h0000_0038, 1'b0, '0);
        run_line(1, 1'b0);
        check("cwf_data", mem_data.data, {32'h0F, 32'h0E, 32'h0D, 32'h0C});
        @(negedge clk);

        // Spurious ack while idle.
        rc0 = ready_cnt;
        ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        @(negedge clk);
        check("spur_busy", {127'd0, busy}, 128'd0);
        check("spur_en", {127'd0, ram_en}, 128'd0);
        check("spur_ready", ready_cnt - rc0, 128'd0);

        // Request during XFER is ignored.
        exp_addr_q = '{30'h102, 30'h103};
        send_req(32'h0000_0400, 1'b0, '0);
        do_beat(0, b_addr, b_we, b_wdata, b_wait);
        do_beat(0, b_addr, b_we, b_wdata, b_wait);
        send_req(32'h0000_0500, 1'b1, {4{32'hFFFF_FFFF}});
        for (int k = 0; k < 2; k++) begin
            do_beat(0, b_addr, b_we, b_wdata, b_wait);
            check("xfer_req_addr", {98'd0, b_addr}, {98'd0, exp_addr_q.pop_front()});
            check("xfer_req_we", {127'd0, b_we}, 128'd0);
        end
        check("xfer_req_data", mem_data.data, {32'h103, 32'h102, 32'h101, 32'h100});
        repeat (3) @(negedge clk);
        check("xfer_req_en", {127'd0, ram_en}, 128'd0);
        check("xfer_req_busy", {127'd0, busy}, 128'd0);
        check("xfer_req_ready", ready_cnt - rc0, 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
